join_any_mem: RTL and testbench

//  AHB-Lite single-transfer slave backing the global die-memory map loaded by the AHB SRAM loader.

---
 rtl/join_any_mem.sv | 113 +++++++++++
 tb/tb_join_any_mem.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/join_any_mem.sv
// AHB-Lite single-transfer slave for the four-die ITCM/DTCM memory map.
// One address phase in flight; ERROR responses take two cycles, OKAY phases add WAIT_STATES.
module join_any_mem #(
    parameter int unsigned REGION_WORDS = 16384,
    parameter logic [31:0] ITCM_BASE    = 32'h0001_0000,
    parameter logic [31:0] DTCM_BASE    = 32'h0005_0000,
    parameter int unsigned WAIT_STATES  = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] haddr,
    input  logic        hwrite,
    input  logic [31:0] hwdata,
    input  logic [1:0]  htrans,
    input  logic [2:0]  hsize,
    input  logic        hsel,
    input  logic [2:0]  hburst,
    input  logic        hreadyin,
    output logic        hready,
    output logic [31:0] hrdata,
    output logic [1:0]  hresp
);

    localparam int unsigned IW           = $clog2(REGION_WORDS);
    localparam int unsigned MW           = IW + 3;
    localparam logic [31:0] REGION_BYTES = 32'(4 * REGION_WORDS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      wcnt_q, wcnt_d;
    logic            wr_q;
    logic [MW-1:0]   idx_q;
    logic [31:0]     rd_q;
    logic [31:0]     mem [0:(1 << MW) - 1];

    logic [31:0]     off, itcm_rel, dtcm_rel;
    logic            in_map, itcm_hit, dtcm_hit, req_err;
    logic [MW-1:0]   req_idx;
    logic            accept, complete_wr;
    logic            unused_ok;

    assign unused_ok = ^{hburst, hreadyin, htrans[0], itcm_rel[31:IW+2], itcm_rel[1:0],
                         dtcm_rel[31:IW+2], dtcm_rel[1:0]};

    // Memory index is {die, region, word} so all eight regions share one array.
    always_comb begin
        off      = {11'b0, haddr[20:0]};
        itcm_rel = off - ITCM_BASE;
        dtcm_rel = off - DTCM_BASE;
        in_map   = (haddr[31:23] == 9'h002);
        itcm_hit = (off >= ITCM_BASE) && (off < ITCM_BASE + REGION_BYTES);
        dtcm_hit = (off >= DTCM_BASE) && (off < DTCM_BASE + REGION_BYTES);
        req_err  = !in_map || !(itcm_hit || dtcm_hit) || (haddr[1:0] != 2'b00) || (hsize != 3'b010);
        req_idx  = {haddr[22:21], dtcm_hit, dtcm_hit ? dtcm_rel[IW+1:2] : itcm_rel[IW+1:2]};
    end

    assign hready      = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR2);
    assign hresp       = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? 2'b01 : 2'b00;
    assign hrdata      = ((state_q == ST_DONE) && !wr_q) ? rd_q : '0;
    assign accept      = hsel && htrans[1] && hready;
    assign complete_wr = (state_q == ST_DONE) && wr_q;

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            ST_WAIT: begin
                if (wcnt_q == 3'd0) state_d = ST_DONE;
                else                wcnt_d  = wcnt_q - 3'd1;
            end
            ST_ERR1: state_d = ST_ERR2;
            default: state_d = ST_IDLE;
        endcase
        if (accept) begin
            if (req_err)               state_d = ST_ERR1;
            else if (WAIT_STATES == 0) state_d = ST_DONE;
            else begin
                state_d = ST_WAIT;
                wcnt_d  = 3'(WAIT_STATES - 1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            wcnt_q  <= '0;
            wr_q    <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            if (accept) begin
                wr_q  <= hwrite;
                idx_q <= req_idx;
            end
        end
    end

    // A read accepted on the edge that retires a write to the same word takes hwdata directly.
    always_ff @(posedge clk) begin
        if (complete_wr) mem[idx_q] <= hwdata;
        if (accept) rd_q <= (complete_wr && (idx_q == req_idx)) ? hwdata : mem[req_idx];
    end

endmodule

// File: tb/tb_join_any_mem.sv
// Bench for join_any_mem: zero-wait instance (vectors, pipelining, random vs model)
// and a WAIT_STATES=2 instance (wait timing, mid-phase reset).
module tb_join_any_mem;

    logic        clk;
    logic        rst_n  [2];
    logic [31:0] haddr  [2];
    logic [31:0] hwdata [2];
    logic [31:0] hrdata [2];
    logic        hwrite [2];
    logic        hsel   [2];
    logic        hready [2];
    logic [1:0]  htrans [2];
    logic [1:0]  hresp  [2];
    logic [2:0]  hsize  [2];

    int n_vec = 0;
    int n_err = 0;

    join_any_mem #(.WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n[0]), .haddr(haddr[0]), .hwrite(hwrite[0]), .hwdata(hwdata[0]),
        .htrans(htrans[0]), .hsize(hsize[0]), .hsel(hsel[0]), .hburst(3'b000), .hreadyin(1'b0),
        .hready(hready[0]), .hrdata(hrdata[0]), .hresp(hresp[0])
    );

    join_any_mem #(.WAIT_STATES(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n[1]), .haddr(haddr[1]), .hwrite(hwrite[1]), .hwdata(hwdata[1]),
        .htrans(htrans[1]), .hsize(hsize[1]), .hsel(hsel[1]), .hburst(3'b000), .hreadyin(1'b0),
        .hready(hready[1]), .hrdata(hrdata[1]), .hresp(hresp[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] addr;
        logic        w;
        logic [31:0] wd;
        logic [2:0]  sz;
        logic        err;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vt[$];
    logic [31:0] mdl [int unsigned];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] a, input logic w, input logic [31:0] wd,
                                input logic [2:0] sz, input logic err, input logic [31:0] exp_rd);
        vec_t v;
        v.addr = a; v.w = w; v.wd = wd; v.sz = sz; v.err = err; v.exp_rd = exp_rd;
        return v;
    endfunction

    // Error rule from the address map, written as plain arithmetic.
    function automatic bit ref_err(input logic [31:0] a, input logic [2:0] sz);
        int unsigned off;
        bit in_map, in_reg;
        in_map = (a / 32'h0080_0000) == 2;
        off    = a % 32'h0020_0000;
        in_reg = (off >= 32'h1_0000 && off < 32'h2_0000) || (off >= 32'h5_0000 && off < 32'h6_0000);
        return !(in_map && in_reg && (a % 4 == 0) && sz == 3'b010);
    endfunction

    task automatic xfer(input int d, input logic [31:0] a, input logic w, input logic [31:0] wd,
                        input logic [2:0] sz, output logic [1:0] resp, output logic [1:0] resp1,
                        output logic [31:0] rd, output int waits, output bit zero_ok);
        haddr[d] = a; hwrite[d] = w; hsize[d] = sz; hsel[d] = 1'b1; htrans[d] = 2'b10;
        @(posedge clk); #1;
        hsel[d] = 1'b0; htrans[d] = 2'b00; hwdata[d] = wd;
        waits = 0; zero_ok = 1'b1; resp1 = hresp[d];
        while (hready[d] !== 1'b1 && waits < 20) begin
            if (hrdata[d] !== 32'h0) zero_ok = 1'b0;
            waits++;
            @(posedge clk); #1;
        end
        resp = hresp[d];
        rd   = hrdata[d];
        @(posedge clk); #1;
        if (hrdata[d] !== 32'h0) zero_ok = 1'b0;
    endtask

    initial begin
        logic [1:0]  resp, resp1;
        logic [31:0] rd, a, wd;
        logic [2:0]  sz;
        logic        w;
        int          waits;
        bit          zok, e;
        int unsigned pool_idx [4];

        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0; haddr[d] = '0; hwdata[d] = '0; hwrite[d] = 1'b0;
            hsel[d] = 1'b0; htrans[d] = 2'b00; hsize[d] = 3'b010;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset hready d%0d", d), 32'(hready[d]), 32'd1);
            check($sformatf("reset hresp d%0d", d), 32'(hresp[d]), 32'd0);
            check($sformatf("reset hrdata d%0d", d), hrdata[d], 32'h0);
        end
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;
        @(posedge clk); #1;

        vt.push_back(mk(32'h0101_0000, 1, 32'hDEAD_BEEF, 3'b010, 0, 32'h0));
        vt.push_back(mk(32'h0101_0000, 0, 32'h0,         3'b010, 0, 32'hDEAD_BEEF));
        vt.push_back(mk(32'h0105_FFFC, 1, 32'h0BAD_F00D, 3'b010, 0, 32'h0));
        vt.push_back(mk(32'h0165_FFFC, 1, 32'h1234_5678, 3'b010, 0, 32'h0));
        vt.push_back(mk(32'h0105_FFFC, 0, 32'h0,         3'b010, 0, 32'h0BAD_F00D));
        vt.push_back(mk(32'h0165_FFFC, 0, 32'h0,         3'b010, 0, 32'h1234_5678));
        vt.push_back(mk(32'h0102_0000, 0, 32'h0,         3'b010, 1, 32'h0));
        vt.push_back(mk(32'h0101_0004, 1, 32'h1111_1111, 3'b010, 0, 32'h0));
        vt.push_back(mk(32'h0101_0004, 1, 32'h2222_2222, 3'b000, 1, 32'h0));
        vt.push_back(mk(32'h0101_0004, 0, 32'h0,         3'b010, 0, 32'h1111_1111));
        vt.push_back(mk(32'h0101_0006, 0, 32'h0,         3'b010, 1, 32'h0));
        vt.push_back(mk(32'h0180_0000, 0, 32'h0,         3'b010, 1, 32'h0));
        vt.push_back(mk(32'h0081_0000, 1, 32'h3333_3333, 3'b010, 1, 32'h0));
        vt.push_back(mk(32'h0104_FFFC, 1, 32'h4444_4444, 3'b010, 1, 32'h0));
        vt.push_back(mk(32'h0106_0000, 0, 32'h0,         3'b010, 1, 32'h0));
        vt.push_back(mk(32'h0101_FFFC, 1, 32'hCAFE_F00D, 3'b010, 0, 32'h0));
        vt.push_back(mk(32'h0101_FFFC, 0, 32'h0,         3'b010, 0, 32'hCAFE_F00D));
        vt.push_back(mk(32'h0125_0000, 1, 32'h55AA_55AA, 3'b010, 0, 32'h0));
        vt.push_back(mk(32'h0125_0000, 0, 32'h0,         3'b010, 0, 32'h55AA_55AA));

        foreach (vt[i]) begin
            xfer(0, vt[i].addr, vt[i].w, vt[i].wd, vt[i].sz, resp, resp1, rd, waits, zok);
            check($sformatf("v%0d hresp", i), 32'(resp), vt[i].err ? 32'd1 : 32'd0);
            check($sformatf("v%0d hresp_c1", i), 32'(resp1), vt[i].err ? 32'd1 : 32'd0);
            check($sformatf("v%0d waits", i), 32'(waits), vt[i].err ? 32'd1 : 32'd0);
            check($sformatf("v%0d hrdata", i), rd, vt[i].exp_rd);
            check($sformatf("v%0d hrdata_idle", i), 32'(zok), 32'd1);
        end

        // Pipelined write then read of the same word.
        xfer(0, 32'h0141_0008, 1, 32'h0, 3'b010, resp, resp1, rd, waits, zok);
        haddr[0] = 32'h0141_0008; hwrite[0] = 1'b1; hsize[0] = 3'b010; hsel[0] = 1'b1; htrans[0] = 2'b10;
        @(posedge clk); #1;
        hwdata[0] = 32'hA5A5_A5A5; hwrite[0] = 1'b0;
        check("b2b write hready", 32'(hready[0]), 32'd1);
        @(posedge clk); #1;
        hsel[0] = 1'b0; htrans[0] = 2'b00;
        check("b2b read hready", 32'(hready[0]), 32'd1);
        check("b2b read hresp", 32'(hresp[0]), 32'd0);
        check("b2b read hrdata", hrdata[0], 32'hA5A5_A5A5);
        @(posedge clk); #1;
        xfer(0, 32'h0141_0008, 0, 32'h0, 3'b010, resp, resp1, rd, waits, zok);
        check("b2b reread hrdata", rd, 32'hA5A5_A5A5);

        // Random traffic against the address-map model.
        pool_idx[0] = 0; pool_idx[1] = 1; pool_idx[2] = 7; pool_idx[3] = 16383;
        mdl[32'h0141_0008] = 32'hA5A5_A5A5;
        for (int n = 0; n < 200; n++) begin
            a  = 32'h0100_0000 + $urandom_range(0, 3) * 32'h20_0000
               + ($urandom_range(0, 1) ? 32'h5_0000 : 32'h1_0000) + pool_idx[$urandom_range(0, 3)] * 4;
            sz = 3'b010;
            case ($urandom_range(0, 9))
                0: a = a + 32'h2_0000;
                1: a = a | 32'h2;
                2: sz = 3'($urandom_range(0, 1));
                3: a = $urandom;
                default: ;
            endcase
            w  = 1'($urandom_range(0, 1));
            wd = $urandom;
            e  = ref_err(a, sz);
            xfer(0, a, w, wd, sz, resp, resp1, rd, waits, zok);
            check($sformatf("rnd%0d hresp a=%h", n, a), 32'(resp), e ? 32'd1 : 32'd0);
            check($sformatf("rnd%0d waits a=%h", n, a), 32'(waits), e ? 32'd1 : 32'd0);
            if (e || w) check($sformatf("rnd%0d hrdata a=%h", n, a), rd, 32'h0);
            else if (mdl.exists(a)) check($sformatf("rnd%0d hrdata a=%h", n, a), rd, mdl[a]);
            if (!e && w) mdl[a] = wd;
        end

        // Wait-state instance.
        xfer(1, 32'h0141_0008, 1, 32'h0000_0077, 3'b010, resp, resp1, rd, waits, zok);
        check("ws2 write waits", 32'(waits), 32'd2);
        check("ws2 write hresp", 32'(resp), 32'd0);
        xfer(1, 32'h0141_0008, 0, 32'h0, 3'b010, resp, resp1, rd, waits, zok);
        check("ws2 read waits", 32'(waits), 32'd2);
        check("ws2 read hrdata", rd, 32'h0000_0077);
        check("ws2 read hrdata_idle", 32'(zok), 32'd1);
        xfer(1, 32'h0102_0000, 0, 32'h0, 3'b010, resp, resp1, rd, waits, zok);
        check("ws2 err waits", 32'(waits), 32'd1);
        check("ws2 err hresp", 32'(resp), 32'd1);

        // Reset pulsed during a write's wait cycles.
        haddr[1] = 32'h0141_0008; hwrite[1] = 1'b1; hsize[1] = 3'b010; hsel[1] = 1'b1; htrans[1] = 2'b10;
        @(posedge clk); #1;
        hsel[1] = 1'b0; htrans[1] = 2'b00; hwdata[1] = 32'h0000_0099;
        check("mid hready before rst", 32'(hready[1]), 32'd0);
        rst_n[1] = 1'b0;
        #1;
        check("mid rst hready", 32'(hready[1]), 32'd1);
        check("mid rst hresp", 32'(hresp[1]), 32'd0);
        check("mid rst hrdata", hrdata[1], 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n[1] = 1'b1;
        @(posedge clk); #1;
        xfer(1, 32'h0141_0008, 0, 32'h0, 3'b010, resp, resp1, rd, waits, zok);
        check("mid rst no write", rd, 32'h0000_0077);
        check("mid rst read waits", 32'(waits), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
